nes_bus_responder: RTL and testbench

NES-side responder for the 6502 CPU bus, sitting opposite the CPU on the NES/CPU interface. It generates the CPU clock, reset and interrupt lines. It decodes each CPU bus cycle into internal work RAM, PPU registers, APU/IO or cartridge space, and returns read data or forwards write data before the cycle ends. Downstream targets use a req/ack handshake bounded by the CPU cycle length; unanswered reads return open-bus data.

---
 rtl/nes_bus_pkg.sv | 26 ++
 rtl/nes_wram.sv | 39 +++
 rtl/nes_bus_responder.sv | 181 ++++++++++++++++++
 tb/tb_nes_bus_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// Shared types and address map for the NES-side 6502 bus responder.
package nes_bus_pkg;

    typedef enum logic [1:0] {RGN_WRAM, RGN_PPU, RGN_IO, RGN_CART} region_e;
    typedef enum logic [1:0] {RST_HOLD, IDLE, ACCESS, DONE} state_e;

    localparam int WRAM_AW = 11;

    localparam logic [15:0] WRAM_LIMIT = 16'h1FFF;
    localparam logic [15:0] PPU_BASE   = 16'h2000;
    localparam logic [15:0] PPU_LIMIT  = 16'h3FFF;
    localparam logic [15:0] IO_BASE    = 16'h4000;
    localparam logic [15:0] IO_LIMIT   = 16'h401F;

    // Everything above the IO window ($4020-$FFFF) belongs to the cartridge.
    function automatic region_e addr_region(input logic [15:0] a);
        if (a <= WRAM_LIMIT)
            return RGN_WRAM;
        if (a >= PPU_BASE && a <= PPU_LIMIT)
            return RGN_PPU;
        if (a >= IO_BASE && a <= IO_LIMIT)
            return RGN_IO;
        return RGN_CART;
    endfunction

endpackage

// File: rtl/nes_wram.sv
// 2 KB internal work RAM; registered read, single-cycle ack pulse per request.
module nes_wram
    import nes_bus_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [WRAM_AW-1:0] addr_i,
    input  logic [DW-1:0]      wdata_i,
    output logic [DW-1:0]      rdata_o,
    output logic               ack_o
);

    logic [DW-1:0] mem_q [2**WRAM_AW];
    logic [DW-1:0] rdata_q;
    logic          ack_q;

    always_ff @(posedge clk) begin
        if (req_i && we_i)
            mem_q[addr_i] <= wdata_i;
        if (req_i)
            rdata_q <= mem_q[addr_i];
    end

    // Pulse rather than level so a still-high req cannot be acked twice.
    always_ff @(posedge clk) begin
        if (srst)
            ack_q <= 1'b0;
        else
            ack_q <= req_i & ~ack_q;
    end

    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;

endmodule

// File: rtl/nes_bus_responder.sv
// NES-side 6502 bus responder: CPU clock/reset/interrupt generation, address decode
// and a req/ack handshake to WRAM, PPU, APU/IO and cartridge, with an open-bus latch.
module nes_bus_responder
    import nes_bus_pkg::*;
#(
    parameter int Dt_sz   = 8,
    parameter int Ad_sz   = 16,
    parameter int CLK_DIV = 12,
    parameter int RST_CYC = 8
) (
    input  logic             NES_clk,
    input  logic             NES_b_rst,
    output logic             clk,
    input  logic             phi2,
    output logic             b_rst,
    output logic             b_nmi,
    output logic             b_irq,
    input  logic             r_bw,
    input  logic [Ad_sz-1:0] addr,
    output logic [Dt_sz-1:0] data_in,
    input  logic [Dt_sz-1:0] data_out,
    output logic             ppu_req,
    output logic             ppu_we,
    output logic [2:0]       ppu_addr,
    output logic [Dt_sz-1:0] ppu_wdata,
    input  logic [Dt_sz-1:0] ppu_rdata,
    input  logic             ppu_ack,
    output logic             io_req,
    output logic             io_we,
    output logic [4:0]       io_addr,
    output logic [Dt_sz-1:0] io_wdata,
    input  logic [Dt_sz-1:0] io_rdata,
    input  logic             io_ack,
    output logic             cart_req,
    output logic             cart_we,
    output logic [Ad_sz-1:0] cart_addr,
    output logic [Dt_sz-1:0] cart_wdata,
    input  logic [Dt_sz-1:0] cart_rdata,
    input  logic             cart_ack,
    input  logic             ppu_nmi,
    input  logic             irq_src
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [CW-1:0] PH2_START = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] ACC_LAST  = CW'(CLK_DIV - 2);
    localparam logic [CW-1:0] CYC_LAST  = CW'(CLK_DIV - 1);

    state_e           state_q;
    region_e          rgn_q;
    region_e          rgn_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [RW-1:0]    rcyc_q;
    logic             clk_q;
    logic             b_rst_q;
    logic             b_nmi_q;
    logic             b_irq_q;
    logic [3:0]       req_q;
    logic [3:0]       we_q;
    logic             acc_we_q;
    logic [Ad_sz-1:0] acc_addr_q;
    logic [Dt_sz-1:0] acc_wdata_q;
    logic [Dt_sz-1:0] obus_q;
    logic             wram_ack;
    logic [Dt_sz-1:0] wram_rdata;
    logic             ack_sel;
    logic [Dt_sz-1:0] rdata_sel;
    logic             unused_phi2;

    assign unused_phi2 = phi2;
    assign rgn_d = addr_region(addr);
    assign cnt_d = (cnt_q == CYC_LAST) ? '0 : cnt_q + 1'b1;

    nes_wram #(.DW(Dt_sz)) u_wram (
        .clk     (NES_clk),
        .srst    (NES_b_rst),
        .req_i   (req_q[RGN_WRAM]),
        .we_i    (we_q[RGN_WRAM]),
        .addr_i  (acc_addr_q[WRAM_AW-1:0]),
        .wdata_i (acc_wdata_q),
        .rdata_o (wram_rdata),
        .ack_o   (wram_ack)
    );

    // Only the target latched for this cycle may complete it.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = cart_rdata;
        case (rgn_q)
            RGN_WRAM: begin ack_sel = wram_ack; rdata_sel = wram_rdata; end
            RGN_PPU:  begin ack_sel = ppu_ack;  rdata_sel = ppu_rdata;  end
            RGN_IO:   begin ack_sel = io_ack;   rdata_sel = io_rdata;   end
            default:  begin ack_sel = cart_ack; rdata_sel = cart_rdata; end
        endcase
    end

    always_ff @(posedge NES_clk) begin
        if (NES_b_rst) begin
            state_q     <= RST_HOLD;
            cnt_q       <= '0;
            clk_q       <= 1'b0;
            rcyc_q      <= '0;
            b_rst_q     <= 1'b0;
            b_nmi_q     <= 1'b1;
            b_irq_q     <= 1'b1;
            req_q       <= '0;
            we_q        <= '0;
            acc_we_q    <= 1'b0;
            rgn_q       <= RGN_WRAM;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            obus_q      <= '0;
        end else begin
            cnt_q   <= cnt_d;
            clk_q   <= (cnt_d >= PH2_START);
            b_nmi_q <= ~ppu_nmi;
            b_irq_q <= ~irq_src;
            case (state_q)
                RST_HOLD: begin
                    if (cnt_q == CYC_LAST) begin
                        if (rcyc_q == RW'(RST_CYC - 1)) begin
                            state_q <= IDLE;
                            b_rst_q <= 1'b1;
                        end else begin
                            rcyc_q <= rcyc_q + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (cnt_q == PH2_START) begin
                        rgn_q       <= rgn_d;
                        acc_addr_q  <= addr;
                        acc_wdata_q <= data_out;
                        acc_we_q    <= ~r_bw;
                        req_q       <= 4'b0001 << rgn_d;
                        we_q        <= r_bw ? 4'b0000 : (4'b0001 << rgn_d);
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack on the last window slot wins over the timeout.
                    if (ack_sel || cnt_q == ACC_LAST) begin
                        req_q   <= '0;
                        we_q    <= '0;
                        state_q <= DONE;
                        if (acc_we_q)
                            obus_q <= acc_wdata_q;
                        else if (ack_sel)
                            obus_q <= rdata_sel;
                    end
                end
                DONE: begin
                    if (cnt_q == CYC_LAST)
                        state_q <= IDLE;
                end
                default: state_q <= RST_HOLD;
            endcase
        end
    end

    assign clk        = clk_q;
    assign b_rst      = b_rst_q;
    assign b_nmi      = b_nmi_q;
    assign b_irq      = b_irq_q;
    assign data_in    = obus_q;
    assign ppu_req    = req_q[RGN_PPU];
    assign ppu_we     = we_q[RGN_PPU];
    assign ppu_addr   = acc_addr_q[2:0];
    assign ppu_wdata  = acc_wdata_q;
    assign io_req     = req_q[RGN_IO];
    assign io_we      = we_q[RGN_IO];
    assign io_addr    = acc_addr_q[4:0];
    assign io_wdata   = acc_wdata_q;
    assign cart_req   = req_q[RGN_CART];
    assign cart_we    = we_q[RGN_CART];
    assign cart_addr  = acc_addr_q;
    assign cart_wdata = acc_wdata_q;

endmodule

// File: tb/tb_nes_bus_responder.sv
// Randomized bench for nes_bus_responder against a transaction-level model of the bus.
module tb_nes_bus_responder;

    logic        NES_clk = 1'b0;
    logic        NES_b_rst = 1'b1;
    logic        clk, phi2, b_rst, b_nmi, b_irq, r_bw;
    logic [15:0] addr;
    logic [7:0]  data_in, data_out;
    logic        ppu_req, ppu_we, ppu_ack;
    logic [2:0]  ppu_addr;
    logic [7:0]  ppu_wdata, ppu_rdata;
    logic        io_req, io_we, io_ack;
    logic [4:0]  io_addr;
    logic [7:0]  io_wdata, io_rdata;
    logic        cart_req, cart_we, cart_ack;
    logic [15:0] cart_addr;
    logic [7:0]  cart_wdata, cart_rdata;
    logic        ppu_nmi, irq_src;

    int          n_checks = 0;
    int          n_fail = 0;
    int          ph = 0;
    int          n_txn = 0;
    logic [7:0]  wram_model [2048];
    logic [7:0]  obus_model = 8'h00;
    logic        irq_rand_en = 1'b0;

    always #5 NES_clk = ~NES_clk;
    assign phi2 = clk;

    nes_bus_responder dut (
        .NES_clk(NES_clk), .NES_b_rst(NES_b_rst), .clk(clk), .phi2(phi2),
        .b_rst(b_rst), .b_nmi(b_nmi), .b_irq(b_irq), .r_bw(r_bw), .addr(addr),
        .data_in(data_in), .data_out(data_out),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
        .ppu_rdata(ppu_rdata), .ppu_ack(ppu_ack),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack),
        .cart_req(cart_req), .cart_we(cart_we), .cart_addr(cart_addr), .cart_wdata(cart_wdata),
        .cart_rdata(cart_rdata), .cart_ack(cart_ack),
        .ppu_nmi(ppu_nmi), .irq_src(irq_src)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One NES_clk: interrupt pins must show the inverted source from before the edge.
    task automatic step();
        logic n0, i0, r0, exp_nmi, exp_irq, exp_clk;
        n0 = ppu_nmi;
        i0 = irq_src;
        r0 = NES_b_rst;
        @(posedge NES_clk);
        #1;
        ph = r0 ? 0 : (ph + 1) % 12;
        exp_nmi = r0 ? 1'b1 : !n0;
        exp_irq = r0 ? 1'b1 : !i0;
        exp_clk = (ph >= 6);
        check("b_nmi", b_nmi, exp_nmi);
        check("b_irq", b_irq, exp_irq);
        check("clk", clk, exp_clk);
        if (irq_rand_en) begin
            ppu_nmi = ($urandom_range(0, 3) == 0);
            irq_src = ($urandom_range(0, 3) == 0);
        end
    endtask

    // One full CPU cycle. dly = NES_clk after req rise at which the target acks;
    // 0..3 lands in the window, 4 is a late ack after timeout, 5 is no ack at all.
    task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                             input int dly, input logic [7:0] rd);
        int         rg;
        logic       ext, we_exp;
        logic [2:0] exp_req;
        while (ph != 0) step();
        if (a < 16'h2000)      rg = 0;
        else if (a < 16'h4000) rg = 1;
        else if (a < 16'h4020) rg = 2;
        else                   rg = 3;
        ext     = (rg != 0);
        exp_req = ext ? 3'(1 << (rg - 1)) : 3'b000;
        we_exp  = !rw;
        addr = a; r_bw = rw; data_out = wd;
        ppu_rdata  = (rg == 1) ? rd : 8'($urandom);
        io_rdata   = (rg == 2) ? rd : 8'($urandom);
        cart_rdata = (rg == 3) ? rd : 8'($urandom);
        if (!rw) begin
            obus_model = wd;
            if (rg == 0) wram_model[a[10:0]] = wd;
        end else if (rg == 0) begin
            obus_model = wram_model[a[10:0]];
        end else if (dly <= 3) begin
            obus_model = rd;
        end
        for (int p = 1; p <= 12; p++) begin
            step();
            if (p == 6) check("req_pre", {cart_req, io_req, ppu_req}, 3'b000);
            if (p == 7) begin
                check("req", {cart_req, io_req, ppu_req}, exp_req);
                case (rg)
                    1: begin
                        check("ppu_addr", ppu_addr, a[2:0]);
                        check("ppu_we", ppu_we, we_exp);
                        if (!rw) check("ppu_wdata", ppu_wdata, wd);
                    end
                    2: begin
                        check("io_addr", io_addr, a[4:0]);
                        check("io_we", io_we, we_exp);
                        if (!rw) check("io_wdata", io_wdata, wd);
                    end
                    3: begin
                        check("cart_addr", cart_addr, a);
                        check("cart_we", cart_we, we_exp);
                        if (!rw) check("cart_wdata", cart_wdata, wd);
                    end
                    default: ;
                endcase
            end
            if (p == 10 && ext && dly >= 4)
                check("req_hold", {cart_req, io_req, ppu_req}, exp_req);
            if (p == 11) begin
                check("req_end", {cart_req, io_req, ppu_req}, 3'b000);
                check("data_in", data_in, obus_model);
            end
            ppu_ack  = (p < 12) && ((rg == 1) ? (p == 7 + dly) : ($urandom_range(0, 4) == 0));
            io_ack   = (p < 12) && ((rg == 2) ? (p == 7 + dly) : ($urandom_range(0, 4) == 0));
            cart_ack = (p < 12) && ((rg == 3) ? (p == 7 + dly) : ($urandom_range(0, 4) == 0));
        end
        n_txn++;
        $display("txn %0d addr=%h rw=%0d wd=%h dly=%0d data_in=%h", n_txn, a, rw, wd, dly, data_in);
    endtask

    initial begin
        int   cycles;
        logic seen_req;
        logic [15:0] ra;
        logic rrw;
        int   rdly;

        addr = 16'h2002; r_bw = 1'b1; data_out = 8'h00;
        ppu_rdata = 8'h00; io_rdata = 8'h00; cart_rdata = 8'h00;
        ppu_ack = 1'b0; io_ack = 1'b0; cart_ack = 1'b0;
        ppu_nmi = 1'b0; irq_src = 1'b0;

        NES_b_rst = 1'b1;
        repeat (4) step();
        check("rst_b_rst", b_rst, 1'b0);
        check("rst_data_in", data_in, 8'h00);
        check("rst_reqs", {cart_req, io_req, ppu_req}, 3'b000);
        check("rst_wes", {cart_we, io_we, ppu_we}, 3'b000);
        check("rst_addrs", {cart_addr, io_addr, ppu_addr}, 24'h0);
        check("rst_wdatas", {cart_wdata, io_wdata, ppu_wdata}, 24'h0);

        NES_b_rst = 1'b0;
        cycles = 0;
        seen_req = 1'b0;
        while (b_rst !== 1'b1 && cycles < 200) begin
            step();
            cycles++;
            if (ppu_req || io_req || cart_req) seen_req = 1'b1;
        end
        check("rst_len", cycles, 96);
        check("rst_no_req", seen_req, 1'b0);

        ppu_nmi = 1'b1; step(); step();
        ppu_nmi = 1'b0; irq_src = 1'b1; step(); step();
        irq_src = 1'b0; step();

        bus_cycle(16'h0005, 1'b0, 8'hA5, 0, 8'h00);
        bus_cycle(16'h1805, 1'b1, 8'h00, 0, 8'h00);
        bus_cycle(16'h3FFA, 1'b1, 8'h11, 3, 8'h5C);
        bus_cycle(16'h8000, 1'b0, 8'h77, 0, 8'h00);
        bus_cycle(16'h6000, 1'b1, 8'h22, 5, 8'hEE);
        bus_cycle(16'h1FFF, 1'b0, 8'h3C, 0, 8'h00);
        bus_cycle(16'h07FF, 1'b1, 8'h00, 0, 8'h00);
        bus_cycle(16'h2000, 1'b1, 8'h00, 0, 8'h12);
        bus_cycle(16'h3FFF, 1'b0, 8'h4B, 1, 8'h00);
        bus_cycle(16'h4000, 1'b1, 8'h00, 1, 8'h34);
        bus_cycle(16'h401F, 1'b0, 8'h9A, 2, 8'h00);
        bus_cycle(16'h4020, 1'b1, 8'h00, 3, 8'h56);
        bus_cycle(16'hFFFF, 1'b1, 8'h00, 4, 8'hD1);

        for (int i = 0; i < 16; i++)
            bus_cycle(16'(i), 1'b0, 8'($urandom), 0, 8'h00);

        irq_rand_en = 1'b1;
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 3))
                0: ra = {3'b000, 2'($urandom_range(0, 3)), 11'($urandom_range(0, 15))};
                1: ra = 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
                2: ra = 16'h4000 + 16'($urandom_range(0, 31));
                default: ra = 16'($urandom_range(16'h4020, 16'hFFFF));
            endcase
            rrw  = 1'($urandom_range(0, 1));
            rdly = rrw ? $urandom_range(0, 5) : $urandom_range(0, 3);
            bus_cycle(ra, rrw, 8'($urandom), rdly, 8'($urandom));
        end
        irq_rand_en = 1'b0;
        ppu_nmi = 1'b0; irq_src = 1'b0;

        while (ph != 0) step();
        addr = 16'h4015; r_bw = 1'b1; io_rdata = 8'hC3;
        for (int p = 1; p <= 8; p++) step();
        check("mid_io_req", io_req, 1'b1);
        NES_b_rst = 1'b1;
        step();
        check("mid_io_req_rst", io_req, 1'b0);
        check("mid_b_rst", b_rst, 1'b0);
        io_ack = 1'b1;
        step();
        NES_b_rst = 1'b0;
        seen_req = 1'b0;
        repeat (20) begin
            step();
            if (io_req || ppu_req || cart_req) seen_req = 1'b1;
        end
        io_ack = 1'b0;
        check("mid_no_req", seen_req, 1'b0);
        check("mid_data_in", data_in, 8'h00);
        check("mid_b_rst_hold", b_rst, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
